// File: rtl/bp_me_tr_replay_driver.sv
// Trace-replay initiator: walks a ROM of SEND/RECV/WAIT/DONE entries, drives
// the LCE trace command port and checks every LCE response against the ROM.
module bp_me_tr_replay_driver #(
  parameter int unsigned paddr_width_p    = 40,
  parameter int unsigned dword_width_p    = 64,
  parameter int unsigned opcode_width_p   = 4,
  parameter int unsigned rom_addr_width_p = 20,
  localparam int unsigned tr_ring_width_lp = opcode_width_p + paddr_width_p + dword_width_p,
  localparam int unsigned rom_data_width_lp = 4 + tr_ring_width_lp
) (
  input  logic                         clk_i,
  input  logic                         reset_n_i,
  input  logic                         en_i,
  output logic [rom_addr_width_p-1:0]  rom_addr_o,
  input  logic [rom_data_width_lp-1:0] rom_data_i,
  output logic                         tr_pkt_v_o,
  output logic [tr_ring_width_lp-1:0]  tr_pkt_o,
  input  logic                         tr_pkt_yumi_i,
  input  logic                         tr_pkt_v_i,
  input  logic [tr_ring_width_lp-1:0]  tr_pkt_i,
  output logic                         tr_pkt_ready_o,
  output logic                         done_o,
  output logic                         error_o,
  output logic [15:0]                  mismatch_count_o
);

  typedef enum logic [1:0] {StExec, StWait, StHalt} state_e;

  localparam logic [3:0] OpNop  = 4'd0;
  localparam logic [3:0] OpSend = 4'd1;
  localparam logic [3:0] OpRecv = 4'd2;
  localparam logic [3:0] OpWait = 4'd3;
  localparam logic [3:0] OpDone = 4'd4;

  localparam logic [rom_addr_width_p-1:0] PcOne = 1;

  state_e                        r_state;
  logic [rom_addr_width_p-1:0]   r_pc;
  logic [15:0]                   r_wait_cnt;
  logic                          r_send_hold;
  logic                          r_done;
  logic                          r_error;
  logic [15:0]                   r_mismatch_cnt;

  logic [3:0]                    w_op;
  logic [tr_ring_width_lp-1:0]   w_payload;
  logic                          w_in_exec;
  logic                          w_send_v;
  logic                          w_recv_rdy;
  logic                          w_send_fire;
  logic                          w_recv_fire;
  logic                          w_mismatch;
  logic                          w_wait_exp;
  logic                          w_pc_inc;
  logic                          w_pc_ovf;

  assign w_op      = rom_data_i[rom_data_width_lp-1 -: 4];
  assign w_payload = rom_data_i[tr_ring_width_lp-1:0];

  // Decode of the current entry and the handshakes it enables this cycle.
  // Valid/ready are gated by reset so the ports go quiet immediately on assertion.
  always_comb begin
    w_in_exec   = (r_state == StExec);
    w_send_v    = reset_n_i & w_in_exec & (w_op == OpSend) & (en_i | r_send_hold);
    w_recv_rdy  = reset_n_i & w_in_exec & (w_op == OpRecv) & en_i;
    w_send_fire = w_send_v & tr_pkt_yumi_i;
    w_recv_fire = w_recv_rdy & tr_pkt_v_i;
    w_mismatch  = w_recv_fire & (tr_pkt_i != w_payload);
    w_wait_exp  = (r_state == StWait) & (r_wait_cnt == 16'd0);
    w_pc_inc    = (w_in_exec & en_i & (w_op == OpNop)) | w_send_fire | w_recv_fire | w_wait_exp;
    w_pc_ovf    = w_pc_inc & (&r_pc);
  end

  // Replay sequencer: pc, wait counter, send hold and sticky status.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      r_state        <= StExec;
      r_pc           <= '0;
      r_wait_cnt     <= 16'd0;
      r_send_hold    <= 1'b0;
      r_done         <= 1'b0;
      r_error        <= 1'b0;
      r_mismatch_cnt <= 16'd0;
    end else begin
      if (w_mismatch) begin
        r_error <= 1'b1;
        if (r_mismatch_cnt != 16'hFFFF) r_mismatch_cnt <= r_mismatch_cnt + 16'd1;
      end

      // Once offered, a command stays valid and stable until consumed.
      if (w_send_fire)   r_send_hold <= 1'b0;
      else if (w_send_v) r_send_hold <= 1'b1;

      // pc never wraps: overflow freezes it and halts with an error.
      if (w_pc_inc) begin
        if (w_pc_ovf) begin
          r_error <= 1'b1;
          r_done  <= 1'b1;
          r_state <= StHalt;
        end else begin
          r_pc <= r_pc + PcOne;
        end
      end

      unique case (r_state)
        StExec: begin
          if (en_i) begin
            if (w_op == OpWait) begin
              r_wait_cnt <= w_payload[15:0];
              r_state    <= StWait;
            end else if (w_op == OpDone) begin
              r_done  <= 1'b1;
              r_state <= StHalt;
            end else if (w_op > OpDone) begin
              r_error <= 1'b1;
              r_done  <= 1'b1;
              r_state <= StHalt;
            end
          end
        end
        StWait: begin
          if (!w_wait_exp)    r_wait_cnt <= r_wait_cnt - 16'd1;
          else if (!w_pc_ovf) r_state    <= StExec;
        end
        StHalt: ;
        default: r_state <= StHalt;
      endcase
    end
  end

  assign rom_addr_o       = r_pc;
  assign tr_pkt_v_o       = w_send_v;
  assign tr_pkt_o         = w_send_v ? w_payload : '0;
  assign tr_pkt_ready_o   = w_recv_rdy;
  assign done_o           = r_done;
  assign error_o          = r_error;
  assign mismatch_count_o = r_mismatch_cnt;

endmodule

// File: tb/tb_bp_me_tr_replay_driver.sv
// Self-checking bench for the trace-replay driver: a small ROM, an LCE model
// with programmable yumi delay and a scoreboard of expected command packets.
module tb_bp_me_tr_replay_driver;

  localparam int unsigned AW = 5;
  localparam int unsigned TW = 4 + 40 + 64;
  localparam int unsigned RW = 4 + TW;

  localparam logic [3:0] OpNop  = 4'd0;
  localparam logic [3:0] OpSend = 4'd1;
  localparam logic [3:0] OpRecv = 4'd2;
  localparam logic [3:0] OpWait = 4'd3;
  localparam logic [3:0] OpDone = 4'd4;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          en = 1'b0;
  logic [AW-1:0] rom_addr;
  logic [RW-1:0] rom_data;
  logic          pkt_v_o;
  logic [TW-1:0] pkt_o;
  logic          yumi;
  logic          pkt_v_i = 1'b0;
  logic [TW-1:0] pkt_i = '0;
  logic          ready;
  logic          done;
  logic          error;
  logic [15:0]   mcount;

  logic [RW-1:0] rom_mem [0:(1<<AW)-1];
  logic [TW-1:0] exp_q [$];
  int            yumi_delay = 0;
  int            vcnt;
  int            n_tests = 0;
  int            n_fail = 0;

  always #5 clk = ~clk;

  assign rom_data = rom_mem[rom_addr];

  // LCE model: consume the command once it has been valid for yumi_delay cycles.
  assign yumi = pkt_v_o && (vcnt >= yumi_delay);

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n)           vcnt <= 0;
    else if (pkt_v_o && yumi) vcnt <= 0;
    else if (pkt_v_o)       vcnt <= vcnt + 1;
  end

  bp_me_tr_replay_driver #(
    .paddr_width_p   (40),
    .dword_width_p   (64),
    .opcode_width_p  (4),
    .rom_addr_width_p(AW)
  ) dut (
    .clk_i           (clk),
    .reset_n_i       (reset_n),
    .en_i            (en),
    .rom_addr_o      (rom_addr),
    .rom_data_i      (rom_data),
    .tr_pkt_v_o      (pkt_v_o),
    .tr_pkt_o        (pkt_o),
    .tr_pkt_yumi_i   (yumi),
    .tr_pkt_v_i      (pkt_v_i),
    .tr_pkt_i        (pkt_i),
    .tr_pkt_ready_o  (ready),
    .done_o          (done),
    .error_o         (error),
    .mismatch_count_o(mcount)
  );

  task automatic check_eq(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [TW-1:0] mk_pkt(input logic [3:0] opc, input logic [39:0] addr,
                                           input logic [63:0] data);
    return {opc, addr, data};
  endfunction

  function automatic logic [RW-1:0] mk_entry(input logic [3:0] op, input logic [TW-1:0] pl);
    return {op, pl};
  endfunction

  // Scoreboard: every command handshake pops and checks the oldest expected packet.
  always @(negedge clk) begin
    if (reset_n && pkt_v_o && yumi) begin
      if (exp_q.size() == 0) check_eq("sb_unexpected", 128'(exp_q.size()), 128'd1);
      else check_eq("sb_pkt", pkt_o, exp_q.pop_front());
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic rom_clear();
    for (int i = 0; i < (1 << AW); i++) rom_mem[i] = mk_entry(OpDone, '0);
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    en      = 1'b0;
    pkt_v_i = 1'b0;
    pkt_i   = '0;
    exp_q.delete();
    repeat (2) tick();
    reset_n = 1'b1;
    #1;
  endtask

  // Present a response and hold it until the driver accepts it (bounded).
  task automatic send_resp(input string tag, input logic [TW-1:0] pkt);
    bit acc = 1'b0;
    pkt_i   = pkt;
    pkt_v_i = 1'b1;
    #1;
    for (int n = 0; n < 20 && !acc; n++) begin
      if (ready) acc = 1'b1;
      tick();
    end
    pkt_v_i = 1'b0;
    pkt_i   = '0;
    check_eq(tag, 128'(acc), 128'd1);
  endtask

  task automatic run_wait(input string tag, input int n);
    logic [TW-1:0] b;
    int cnt = 0;
    b = mk_pkt(4'h1, 40'h100 + 40'(n), 64'hB0 + 64'(n));
    rom_clear();
    rom_mem[0] = mk_entry(OpWait, TW'(n));
    rom_mem[1] = mk_entry(OpSend, b);
    yumi_delay = 0;
    do_reset();
    exp_q.push_back(b);
    en = 1'b1;
    for (int c = 0; c < 30; c++) begin
      #1;
      if (pkt_v_o) break;
      cnt++;
      tick();
    end
    check_eq({tag, "_cycles"}, 128'(cnt), 128'(n + 2));
    tick();
    tick();
    check_eq({tag, "_done"}, {done, error, 5'(rom_addr)}, {1'b1, 1'b0, 5'd2});
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, n_tests=%0d", n_tests);
    $fatal(1);
  end

  initial begin
    logic [TW-1:0] pa, p1, p2, px, pd;
    int vcyc;

    // T0: reset state
    rom_clear();
    do_reset();
    check_eq("rst_state", {pkt_v_o, ready, done, error, mcount, 5'(rom_addr)}, '0);

    // T1: SEND, RECV matching response, DONE
    pa = mk_pkt(4'h1, 40'h80, 64'hAB);
    rom_clear();
    rom_mem[0] = mk_entry(OpSend, pa);
    rom_mem[1] = mk_entry(OpRecv, pa);
    yumi_delay = 0;
    do_reset();
    exp_q.push_back(pa);
    en = 1'b1;
    #1;
    check_eq("t1_v_cycle0", 128'(pkt_v_o), 128'd1);
    tick();
    tick();
    tick();
    send_resp("t1_accept", pa);
    tick();
    check_eq("t1_done", {done, error, 5'(rom_addr)}, {1'b1, 1'b0, 5'd2});
    check_eq("t1_mcount", 128'(mcount), 128'd0);
    tick();
    check_eq("t1_halt_quiet", {pkt_v_o, ready, 5'(rom_addr)}, {1'b0, 1'b0, 5'd2});

    // T2: delayed yumi, en dropped mid-handshake
    pa = mk_pkt(4'h2, 40'hDEAD0, 64'h1234_5678_9ABC_DEF0);
    rom_clear();
    rom_mem[0] = mk_entry(OpSend, pa);
    rom_mem[1] = mk_entry(OpNop, '0);
    yumi_delay = 5;
    do_reset();
    exp_q.push_back(pa);
    en   = 1'b1;
    vcyc = 0;
    for (int c = 0; c < 10; c++) begin
      if (c == 2) en = 1'b0;
      #1;
      if (pkt_v_o) begin
        vcyc++;
        check_eq("t2_pkt_stable", pkt_o, pa);
      end
      tick();
    end
    check_eq("t2_v_cycles", 128'(vcyc), 128'd6);
    check_eq("t2_pc", 128'(rom_addr), 128'd1);

    // T3: two mismatching responses, replay continues
    p1 = mk_pkt(4'h3, 40'h40, 64'h11);
    p2 = mk_pkt(4'h4, 40'h48, 64'h22);
    rom_clear();
    rom_mem[0] = mk_entry(OpRecv, p1);
    rom_mem[1] = mk_entry(OpRecv, p2);
    yumi_delay = 0;
    do_reset();
    en = 1'b1;
    send_resp("t3_accept1", p1 ^ TW'(1));
    check_eq("t3_mcount1", 128'(mcount), 128'd1);
    send_resp("t3_accept2", {4'h5, p2[TW-5:0]});
    tick();
    check_eq("t3_mcount2", 128'(mcount), 128'd2);
    check_eq("t3_status", {done, error, 5'(rom_addr)}, {1'b1, 1'b1, 5'd2});

    // T4: WAIT 3 and WAIT 0 before a SEND
    run_wait("t4_wait3", 3);
    run_wait("t4_wait0", 0);

    // T5: illegal op at pc 1
    rom_clear();
    rom_mem[0] = mk_entry(OpNop, '0);
    rom_mem[1] = mk_entry(4'd7, mk_pkt(4'h1, 40'h0, 64'h0));
    do_reset();
    en = 1'b1;
    tick();
    check_eq("t5_pre", {done, error, 5'(rom_addr)}, {1'b0, 1'b0, 5'd1});
    tick();
    check_eq("t5_err", {done, error, 5'(rom_addr)}, {1'b1, 1'b1, 5'd1});
    pkt_v_i = 1'b1;
    for (int c = 0; c < 4; c++) begin
      #1;
      check_eq("t5_quiet", {pkt_v_o, ready}, 2'b00);
      tick();
    end
    pkt_v_i = 1'b0;

    // T6: asynchronous reset in the middle of a held SEND
    px = mk_pkt(4'h6, 40'h200, 64'hCAFE);
    pd = mk_pkt(4'h7, 40'h208, 64'hF00D);
    rom_clear();
    rom_mem[0] = mk_entry(OpRecv, px);
    rom_mem[1] = mk_entry(OpSend, pd);
    yumi_delay = 100;
    do_reset();
    en = 1'b1;
    send_resp("t6_accept_bad", px ^ TW'(5));
    exp_q.push_back(pd);
    tick();
    tick();
    check_eq("t6_pre", {pkt_v_o, error, mcount}, {1'b1, 1'b1, 16'd1});
    #1;
    reset_n = 1'b0;
    #1;
    check_eq("t6_async", {pkt_v_o, done, error, mcount, 5'(rom_addr)}, '0);
    exp_q.delete();
    @(posedge clk);
    #1;
    yumi_delay = 0;
    reset_n    = 1'b1;
    exp_q.push_back(pd);
    #1;
    check_eq("t6_restart", {5'(rom_addr), ready}, {5'd0, 1'b1});
    send_resp("t6_accept_good", px);
    tick();
    tick();
    check_eq("t6_final", {done, error, mcount}, {1'b1, 1'b0, 16'd0});

    // T7: pc overflow with a ROM full of NOPs
    for (int i = 0; i < (1 << AW); i++) rom_mem[i] = mk_entry(OpNop, '0);
    do_reset();
    en = 1'b1;
    repeat (34) tick();
    check_eq("t7_ovf", {done, error, 5'(rom_addr)}, {1'b1, 1'b1, 5'd31});

    check_eq("sb_empty", 128'(exp_q.size()), 128'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
